cpu_fsm: RTL and testbench
==========================

Name: cpu_fsm

Overview:
Instruction register plus Moore state machine that sequences the lab datapath: register file, A/B/C pipeline registers, shifter, ALU and status register. It holds one 16-bit instruction, decodes it, and drives the datapath control strobes cycle by cycle. It implements MOV-immediate, MOV-shifted, ADD, CMP, AND and MVN, then returns to an idle handshake state. It sits between the top level (switch/testbench inputs) and the datapath.

Parameters:
None. The instruction width is fixed at 16.

Ports:
clk  input  1  rising-edge clock; the block's only clock
reset  input  1  synchronous, active-high; sampled on rising clk
s  input  1  start: begin executing the held instruction; honoured only in WAIT
load  input  1  capture in into the instruction register; honoured only in WAIT
in  input  16  instruction word
w  output  1  1 = idle in WAIT, ready for load/s
nsel  output  3  register select, one-hot: 100 = Rn, 010 = Rd, 001 = Rm, 000 = none
readnum  output  3  register-file read index selected by nsel (000 when nsel=000)
writenum  output  3  register-file write index; equals readnum
write  output  1  register-file write enable
vsel  output  2  write-back mux: 00 = C (datapath output), 01 = sximm8; others reserved
loada  output  1  load A register
loadb  output  1  load B register
asel  output  1  1 = ALU A input forced to 0
bsel  output  1  1 = ALU B input = sximm5 (always 0 for this instruction set)
shift  output  2  shifter control
ALUop  output  2  00 add, 01 sub, 10 and, 11 not-B
loadc  output  1  load C register
loads  output  1  load status (zero flag)
sximm8  output  16  sign-extended IR[7:0], continuous
sximm5  output  16  sign-extended IR[4:0], continuous

Behaviour:
- Instruction fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Instruction classes: opcode 110 with op 10 is MOV Rn,#imm8; opcode 110 with op 00 is MOV Rd,Rm{sh}; opcode 101 is an ALU instruction with ALUop = op (ADD, CMP, AND, MVN). Every other opcode/op pair is illegal.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG.
- Transitions:
  - WAIT goes to DECODE if s, else stays in WAIT.
  - DECODE goes to WRITE_IMM for MOV-imm; to GET_B for MOV-shift and MVN; to GET_A for ADD, AND and CMP; to WAIT if illegal.
  - GET_A goes to GET_B. GET_B goes to EXEC.
  - EXEC goes to WAIT for CMP, else to WRITE_REG.
  - WRITE_IMM and WRITE_REG go to WAIT.
- Moore outputs by state (anything not listed is 0):
  - WAIT: w=1.
  - WRITE_IMM: nsel=Rn, vsel=01, write=1.
  - GET_A: nsel=Rn, loada=1.
  - GET_B: nsel=Rm, loadb=1, shift=sh.
  - EXEC: shift=sh (00 for MOV-imm, which never reaches EXEC); asel=1 for MOV-shift and MVN; ALUop=op for ALU class, 00 for MOV-shift; loadc=1 except CMP; loads=1 only for CMP.
  - WRITE_REG: nsel=Rd, vsel=00, write=1.
- Latency, counting rising edges from the edge that samples s=1 to the edge that returns to WAIT:
  - MOV-imm: 2.
  - CMP: 4.
  - MOV-shift and MVN: 4.
  - ADD and AND: 5.
  - illegal: 1.
- IR loads in on an edge where load=1 and state=WAIT. load in any other state is ignored, so the IR is stable for the whole instruction.
- load and s together in WAIT: the IR captures in and the state moves to DECODE on the same edge, so the new instruction executes.
- s while not in WAIT is ignored; there is no queueing.
- Reset:
  - At the edge: state becomes WAIT and IR becomes 0.
  - While reset=1: write, loada, loadb, loadc and loads are forced to 0 combinationally, even when reset arrives mid-instruction. No partial write-back occurs.
  - After reset: w=1, all strobes 0, sximm8=sximm5=0.
- sximm8 and sximm5 are combinational from the IR and valid in every state.

Decomposition:
- Shared package/header holds:
  - state encodings;
  - opcode constants (OPC_MOV=110, OPC_ALU=101);
  - op constants (ADD=00, CMP=01, AND=10, MVN=11, MOVI=10, MOVR=00);
  - nsel codes (NSEL_RN, NSEL_RD, NSEL_RM, NSEL_NONE);
  - vsel codes (VSEL_C, VSEL_IMM8).
- One combinational sub-module, instr_dec: IR in; opcode, op, sh, sximm8, sximm5 out; readnum/writenum from an nsel mux.
- The FSM, IR and strobe gating stay in cpu_fsm.

Test Plan:
1. Reset, then load in=16'hD007, then s=1 (MOV R0,#7) -> DECODE, then WRITE_IMM with nsel=100, writenum=000, vsel=01, write=1, sximm8=16'h0007; w=1 after 2 edges.
2. IR=16'hA148, s=1 (ADD R2,R1,R0,LSL#1) -> GET_A (readnum=001, loada), GET_B (readnum=000, loadb, shift=01), EXEC (ALUop=00, asel=0, loadc), WRITE_REG (writenum=010, vsel=00, write); w=1 after 5 edges.
3. IR=16'hA900 (CMP R1,R0) -> EXEC has ALUop=01, loads=1, loadc=0; no WRITE_REG state; write never asserted; back to WAIT after 4 edges.
4. IR=16'hB860 (MVN R3,R0) -> skips GET_A; EXEC has asel=1, ALUop=11; WRITE_REG has writenum=011; in=16'hFFFF applied with load=1 during GET_B leaves the IR unchanged.
5. IR=16'hE000 (illegal) -> DECODE then WAIT; every strobe stays 0 throughout.
6. Start ADD, assert reset for one cycle while in WRITE_REG -> write=0 during the reset cycle; next state WAIT with w=1 and IR=0; a subsequent load and s together in WAIT executes the new instruction.

Source files
------------

// File: rtl/cpu_fsm_pkg.sv
// cpu_fsm_pkg: shared encodings for the instruction-sequencing FSM.
//   - FSM state encoding
//   - opcode / op field constants
//   - nsel (one-hot register select) and vsel (write-back mux) codes
//   - instruction class enum and a classify() helper used by decode/FSM
package cpu_fsm_pkg;

    localparam int IW = 16;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_EXEC      = 3'd5,
        S_WRITE_REG = 3'd6
    } state_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;

    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;
    localparam logic [2:0] NSEL_NONE = 3'b000;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b01;

    typedef enum logic [2:0] {
        I_ILL  = 3'd0,
        I_MOVI = 3'd1,
        I_MOVR = 3'd2,
        I_ADD  = 3'd3,
        I_CMP  = 3'd4,
        I_AND  = 3'd5,
        I_MVN  = 3'd6
    } iclass_e;

    // Control strobes driven toward the datapath, gathered so the output
    // decode can default everything in one assignment.
    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic       write;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       loadc;
        logic       loads;
    } ctrl_t;

    function automatic iclass_e classify(input logic [2:0] opc, input logic [1:0] op);
        iclass_e c;
        c = I_ILL;
        if (opc == OPC_MOV) begin
            if (op == OP_MOVI)      c = I_MOVI;
            else if (op == OP_MOVR) c = I_MOVR;
        end else if (opc == OPC_ALU) begin
            case (op)
                OP_ADD:  c = I_ADD;
                OP_CMP:  c = I_CMP;
                OP_AND:  c = I_AND;
                default: c = I_MVN;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/cpu_fsm_instr_dec.sv
// instr_dec: combinational field split of the instruction register.
//   ir_i        held instruction word
//   nsel_i      one-hot register select (Rn / Rd / Rm / none)
//   opcode_o    IR[15:13]     op_o  IR[12:11]     sh_o  IR[4:3]
//   sximm8_o    sign-extended IR[7:0]
//   sximm5_o    sign-extended IR[4:0]
//   readnum_o   register index picked by nsel_i (0 when none)
//   writenum_o  same index as readnum_o
module instr_dec
    import cpu_fsm_pkg::*;
(
    input  logic [IW-1:0] ir_i,
    input  logic [2:0]    nsel_i,
    output logic [2:0]    opcode_o,
    output logic [1:0]    op_o,
    output logic [1:0]    sh_o,
    output logic [IW-1:0] sximm8_o,
    output logic [IW-1:0] sximm5_o,
    output logic [2:0]    readnum_o,
    output logic [2:0]    writenum_o
);

    logic [2:0] rn, rd, rm;
    logic [2:0] regnum;

    assign opcode_o = ir_i[15:13];
    assign op_o     = ir_i[12:11];
    assign rn       = ir_i[10:8];
    assign rd       = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm       = ir_i[2:0];

    assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
    assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

    always_comb begin
        regnum = 3'b000;
        case (nsel_i)
            NSEL_RN: regnum = rn;
            NSEL_RD: regnum = rd;
            NSEL_RM: regnum = rm;
            default: regnum = 3'b000;
        endcase
    end

    // The register file uses one shared index for read and write.
    assign readnum_o  = regnum;
    assign writenum_o = regnum;

endmodule

// File: rtl/cpu_fsm.sv
// cpu_fsm: instruction register plus Moore FSM that sequences the datapath.
//   clk, reset      clock and synchronous active-high reset
//   s, load, in     start, IR load, instruction word (honoured only in WAIT)
//   w               idle/ready in WAIT
//   nsel, readnum, writenum, write, vsel   register-file controls
//   loada, loadb, asel, bsel, shift, ALUop, loadc, loads  datapath controls
//   sximm8, sximm5  sign-extended immediates from the IR
module cpu_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  nsel,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);
    import cpu_fsm_pkg::*;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [1:0]  sh;
    iclass_e     cls;
    ctrl_t       ctrl;

    instr_dec u_dec (
        .ir_i       (ir_q),
        .nsel_i     (ctrl.nsel),
        .opcode_o   (opcode),
        .op_o       (op),
        .sh_o       (sh),
        .sximm8_o   (sximm8),
        .sximm5_o   (sximm5),
        .readnum_o  (readnum),
        .writenum_o (writenum)
    );

    assign cls = classify(opcode, op);

    // IR only captures in WAIT so it stays stable for the whole instruction.
    assign ir_d = (state_q == S_WAIT && load) ? in : ir_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next state. In WAIT the decode of a same-edge load is taken care of by
    // DECODE reading the freshly captured IR one cycle later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   if (s) state_d = S_DECODE;
            S_DECODE: begin
                case (cls)
                    I_MOVI:               state_d = S_WRITE_IMM;
                    I_MOVR, I_MVN:        state_d = S_GET_B;
                    I_ADD, I_AND, I_CMP:  state_d = S_GET_A;
                    default:              state_d = S_WAIT;
                endcase
            end
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_EXEC;
            S_EXEC:      state_d = (cls == I_CMP) ? S_WAIT : S_WRITE_REG;
            S_WRITE_IMM: state_d = S_WAIT;
            S_WRITE_REG: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Moore outputs: a function of state and the (stable) IR only.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_WAIT: ctrl.w = 1'b1;
            S_WRITE_IMM: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.vsel  = VSEL_IMM8;
                ctrl.write = 1'b1;
            end
            S_GET_A: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.loada = 1'b1;
            end
            S_GET_B: begin
                ctrl.nsel  = NSEL_RM;
                ctrl.loadb = 1'b1;
                ctrl.shift = sh;
            end
            S_EXEC: begin
                ctrl.shift = sh;
                // MOV-shift and MVN pass B through, so zero the A side.
                ctrl.asel  = (cls == I_MOVR) || (cls == I_MVN);
                ctrl.aluop = (opcode == OPC_ALU) ? op : OP_ADD;
                ctrl.loadc = (cls != I_CMP);
                ctrl.loads = (cls == I_CMP);
            end
            S_WRITE_REG: begin
                ctrl.nsel  = NSEL_RD;
                ctrl.vsel  = VSEL_C;
                ctrl.write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign w     = ctrl.w;
    assign nsel  = ctrl.nsel;
    assign vsel  = ctrl.vsel;
    assign asel  = ctrl.asel;
    assign bsel  = ctrl.bsel;
    assign shift = ctrl.shift;
    assign ALUop = ctrl.aluop;

    // Reset kills every state-changing strobe combinationally so a reset
    // landing mid-instruction never produces a partial write-back.
    assign write = ctrl.write & ~reset;
    assign loada = ctrl.loada & ~reset;
    assign loadb = ctrl.loadb & ~reset;
    assign loadc = ctrl.loadc & ~reset;
    assign loads = ctrl.loads & ~reset;

endmodule

// File: tb/tb_cpu_fsm.sv
module tb_cpu_fsm;

    logic        clk = 1'b0;
    logic        reset, s, load;
    logic [15:0] in;
    logic        w, write, loada, loadb, asel, bsel, loadc, loads;
    logic [2:0]  nsel, readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;

    cpu_fsm dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .w(w), .nsel(nsel), .readnum(readnum), .writenum(writenum),
        .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .loadc(loadc), .loads(loads), .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [2:0]  nsel;
        logic [2:0]  rnum;
        logic [2:0]  wnum;
        logic        write;
        logic [1:0]  vsel;
        logic        loada;
        logic        loadb;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic        loadc;
        logic        loads;
        logic [15:0] imm8;
        logic [15:0] imm5;
    } outs_t;

    typedef struct {
        string       tag;
        logic        rst;
        logic        s;
        logic        ld;
        logic [15:0] in;
        outs_t       exp;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic outs_t o_base(input logic [15:0] i8, input logic [15:0] i5);
        outs_t o = '0;
        o.imm8 = i8;
        o.imm5 = i5;
        return o;
    endfunction

    function automatic outs_t o_wait(input logic [15:0] i8, input logic [15:0] i5);
        outs_t o = o_base(i8, i5);
        o.w = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_wimm(input logic [2:0] rn, input logic [15:0] i8, input logic [15:0] i5);
        outs_t o = o_base(i8, i5);
        o.nsel = 3'b100; o.rnum = rn; o.wnum = rn; o.vsel = 2'b01; o.write = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_geta(input logic [2:0] rn, input logic [15:0] i8, input logic [15:0] i5);
        outs_t o = o_base(i8, i5);
        o.nsel = 3'b100; o.rnum = rn; o.wnum = rn; o.loada = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_getb(input logic [2:0] rm, input logic [1:0] sh, input logic [15:0] i8, input logic [15:0] i5);
        outs_t o = o_base(i8, i5);
        o.nsel = 3'b001; o.rnum = rm; o.wnum = rm; o.loadb = 1'b1; o.shift = sh;
        return o;
    endfunction

    function automatic outs_t o_exec(input logic [1:0] sh, input logic as, input logic [1:0] alu,
                                     input logic lc, input logic ls, input logic [15:0] i8, input logic [15:0] i5);
        outs_t o = o_base(i8, i5);
        o.shift = sh; o.asel = as; o.aluop = alu; o.loadc = lc; o.loads = ls;
        return o;
    endfunction

    function automatic outs_t o_wreg(input logic [2:0] rd, input logic wr, input logic [15:0] i8, input logic [15:0] i5);
        outs_t o = o_base(i8, i5);
        o.nsel = 3'b010; o.rnum = rd; o.wnum = rd; o.vsel = 2'b00; o.write = wr;
        return o;
    endfunction

    task automatic add(input string tag, input logic r, input logic st, input logic ld,
                       input logic [15:0] iw, input outs_t e);
        vec_t v;
        v.tag = tag; v.rst = r; v.s = st; v.ld = ld; v.in = iw; v.exp = e;
        tbl.push_back(v);
    endtask

    function automatic outs_t sample();
        return outs_t'({w, nsel, readnum, writenum, write, vsel, loada, loadb,
                        asel, bsel, shift, ALUop, loadc, loads, sximm8, sximm5});
    endfunction

    // Load an instruction, start it, and count edges after the start edge
    // until w returns.
    task automatic run_latency(input string tag, input logic [15:0] instr, input int exp_n);
        int n;
        @(negedge clk);
        reset = 1'b0; load = 1'b1; in = instr; s = 1'b0;
        @(negedge clk);
        load = 1'b0; s = 1'b1;
        @(posedge clk);
        #1 s = 1'b0;
        n = 0;
        while (!w && n < 20) begin
            @(posedge clk);
            n++;
            #1;
        end
        n_tests++;
        if (!w || n != exp_n) begin
            n_fail++;
            $display("FAIL latency_%s: got %0d edges (w=%b), want %0d", tag, n, w, exp_n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t act;
        reset = 1'b1; s = 1'b0; load = 1'b0; in = '0;

        // 1: MOV R0,#7
        add("rst_state",  0, 0, 1, 16'hD007, o_wait(16'h0000, 16'h0000));
        add("movi_wait",  0, 1, 0, 16'h0000, o_wait(16'h0007, 16'h0007));
        add("movi_dec",   0, 0, 0, 16'h0000, o_base(16'h0007, 16'h0007));
        add("movi_wimm",  0, 0, 0, 16'h0000, o_wimm(3'd0, 16'h0007, 16'h0007));
        // 2: ADD R2,R1,R0,LSL#1
        add("movi_done",  0, 0, 1, 16'hA148, o_wait(16'h0007, 16'h0007));
        add("add_wait",   0, 1, 0, 16'h0000, o_wait(16'h0048, 16'h0008));
        add("add_dec",    0, 0, 0, 16'h0000, o_base(16'h0048, 16'h0008));
        add("add_geta",   0, 0, 0, 16'h0000, o_geta(3'd1, 16'h0048, 16'h0008));
        add("add_getb",   0, 0, 0, 16'h0000, o_getb(3'd0, 2'b01, 16'h0048, 16'h0008));
        add("add_exec",   0, 0, 0, 16'h0000, o_exec(2'b01, 0, 2'b00, 1, 0, 16'h0048, 16'h0008));
        add("add_wreg",   0, 0, 0, 16'h0000, o_wreg(3'd2, 1, 16'h0048, 16'h0008));
        // 3: CMP R1,R0
        add("add_done",   0, 0, 1, 16'hA900, o_wait(16'h0048, 16'h0008));
        add("cmp_wait",   0, 1, 0, 16'h0000, o_wait(16'h0000, 16'h0000));
        add("cmp_dec",    0, 0, 0, 16'h0000, o_base(16'h0000, 16'h0000));
        add("cmp_geta",   0, 0, 0, 16'h0000, o_geta(3'd1, 16'h0000, 16'h0000));
        add("cmp_getb",   0, 0, 0, 16'h0000, o_getb(3'd0, 2'b00, 16'h0000, 16'h0000));
        add("cmp_exec",   0, 0, 0, 16'h0000, o_exec(2'b00, 0, 2'b01, 0, 1, 16'h0000, 16'h0000));
        // 4: MVN R3,R0 with a stray load during GET_B
        add("cmp_done",   0, 0, 1, 16'hB860, o_wait(16'h0000, 16'h0000));
        add("mvn_wait",   0, 1, 0, 16'h0000, o_wait(16'h0060, 16'h0000));
        add("mvn_dec",    0, 0, 0, 16'h0000, o_base(16'h0060, 16'h0000));
        add("mvn_getb",   0, 0, 1, 16'hFFFF, o_getb(3'd0, 2'b00, 16'h0060, 16'h0000));
        add("mvn_exec",   0, 0, 0, 16'h0000, o_exec(2'b00, 1, 2'b11, 1, 0, 16'h0060, 16'h0000));
        add("mvn_wreg",   0, 0, 0, 16'h0000, o_wreg(3'd3, 1, 16'h0060, 16'h0000));
        // 5: illegal opcode, s held during DECODE is ignored
        add("mvn_done",   0, 0, 1, 16'hE000, o_wait(16'h0060, 16'h0000));
        add("ill_wait",   0, 1, 0, 16'h0000, o_wait(16'h0000, 16'h0000));
        add("ill_dec",    0, 1, 0, 16'h0000, o_base(16'h0000, 16'h0000));
        // 6: ADD interrupted by reset in WRITE_REG, then load+s together
        add("ill_done",   0, 0, 1, 16'hA148, o_wait(16'h0000, 16'h0000));
        add("add2_wait",  0, 1, 0, 16'h0000, o_wait(16'h0048, 16'h0008));
        add("add2_dec",   0, 0, 0, 16'h0000, o_base(16'h0048, 16'h0008));
        add("add2_geta",  0, 0, 0, 16'h0000, o_geta(3'd1, 16'h0048, 16'h0008));
        add("add2_getb",  0, 0, 0, 16'h0000, o_getb(3'd0, 2'b01, 16'h0048, 16'h0008));
        add("add2_exec",  0, 0, 0, 16'h0000, o_exec(2'b01, 0, 2'b00, 1, 0, 16'h0048, 16'h0008));
        add("add2_rst",   1, 0, 0, 16'h0000, o_wreg(3'd2, 0, 16'h0048, 16'h0008));
        add("post_rst",   0, 1, 1, 16'hD007, o_wait(16'h0000, 16'h0000));
        add("ls_dec",     0, 0, 0, 16'h0000, o_base(16'h0007, 16'h0007));
        add("ls_wimm",    0, 0, 0, 16'h0000, o_wimm(3'd0, 16'h0007, 16'h0007));
        add("ls_done",    0, 0, 0, 16'h0000, o_wait(16'h0007, 16'h0007));

        // Initial reset across two edges.
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; s = tbl[i].s; load = tbl[i].ld; in = tbl[i].in;
            #1;
            act = sample();
            n_tests++;
            if (act !== tbl[i].exp) begin
                n_fail++;
                $display("FAIL %s (row %0d): got %h want %h", tbl[i].tag, i, act, tbl[i].exp);
            end
        end

        // Edge counts from the start edge back to WAIT.
        run_latency("movi", 16'hD007, 2);
        run_latency("add",  16'hA148, 5);
        run_latency("and",  16'hB148, 5);
        run_latency("cmp",  16'hA900, 4);
        run_latency("mvn",  16'hB860, 4);
        run_latency("movr", 16'hC008, 4);
        run_latency("ill",  16'hE000, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
